// File: rtl/conv_controller_if.sv
// Control bus between conv_controller, the host start/done handshake and the
// convolution datapath (enables out, carry-outs in).
interface conv_controller_if;
  logic       start;
  logic       busy;
  logic       done;

  logic       co_cntr4_filter;
  logic       co_cntr16_img;
  logic       co_row_cntr;
  logic       co_col_cntr;
  logic       co_cntr16;
  logic       co_cntr_reg4;
  logic       co_cntr43;
  logic       co_cntr13;

  logic       mem_en;
  logic       wr_file;
  logic       adr_sel;
  logic       filter_wr_en;
  logic       img_wr_en;
  logic       cntr4_filter_en;
  logic       cntr16_img_en;
  logic       row_cntr_en;
  logic       col_cntr_en;
  logic       cntr16_en;
  logic       img_slice_en;
  logic       acc_en;
  logic       cntr_reg4_en;
  logic       res_buffer_en;
  logic       cntr43_en;
  logic       cntr13_en;
  logic       inc_en;
  logic       inc_ld;
  logic       rst_acc;
  logic       rst_res_reg;
  logic [1:0] mem_offset_sel;

  modport slave (
    input  start,
    input  co_cntr4_filter, co_cntr16_img, co_row_cntr, co_col_cntr,
    input  co_cntr16, co_cntr_reg4, co_cntr43, co_cntr13,
    output busy, done,
    output mem_en, wr_file, adr_sel, filter_wr_en, img_wr_en,
    output cntr4_filter_en, cntr16_img_en, row_cntr_en, col_cntr_en,
    output cntr16_en, img_slice_en, acc_en, cntr_reg4_en, res_buffer_en,
    output cntr43_en, cntr13_en, inc_en, inc_ld, rst_acc, rst_res_reg,
    output mem_offset_sel
  );

  modport master (
    output start,
    output co_cntr4_filter, co_cntr16_img, co_row_cntr, co_col_cntr,
    output co_cntr16, co_cntr_reg4, co_cntr43, co_cntr13,
    input  busy, done,
    input  mem_en, wr_file, adr_sel, filter_wr_en, img_wr_en,
    input  cntr4_filter_en, cntr16_img_en, row_cntr_en, col_cntr_en,
    input  cntr16_en, img_slice_en, acc_en, cntr_reg4_en, res_buffer_en,
    input  cntr43_en, cntr13_en, inc_en, inc_ld, rst_acc, rst_res_reg,
    input  mem_offset_sel
  );
endinterface

// File: rtl/conv_controller.sv
// Moore sequencer for the convolution datapath: load filter/image, slice, MAC,
// write back packed results, then pulse done. Outputs are registered per state.
module conv_controller #(
  parameter int DONE_CYCLES = 1
) (
  input logic              clk,
  input logic              rst,
  conv_controller_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, INIT, LD_FLT, LD_IMG, SLICE, MAC, PSUM, RST_ACC, WR, NXT_ROW, FIN, DONE
  } state_e;

  typedef struct packed {
    logic       mem_en;
    logic       wr_file;
    logic       adr_sel;
    logic       filter_wr_en;
    logic       img_wr_en;
    logic       cntr4_filter_en;
    logic       cntr16_img_en;
    logic       row_cntr_en;
    logic       col_cntr_en;
    logic       cntr16_en;
    logic       img_slice_en;
    logic       acc_en;
    logic       cntr_reg4_en;
    logic       res_buffer_en;
    logic       cntr43_en;
    logic       cntr13_en;
    logic       inc_en;
    logic       inc_ld;
    logic       rst_acc;
    logic       rst_res_reg;
    logic [1:0] mem_offset_sel;
    logic       busy;
    logic       done;
  } ctrl_t;

  localparam int CW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

  state_e          state_q, state_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic            col_wrap_q, col_wrap_d;
  logic [CW-1:0]   done_cnt_q, done_cnt_d;

  // Output decode is applied to the next state so the registered outputs line up with state_q.
  function automatic ctrl_t decode(input state_e s);
    ctrl_t c;
    c      = '0;
    c.busy = (s != IDLE);
    case (s)
      INIT:    begin c.inc_ld = 1'b1; c.rst_acc = 1'b1; c.rst_res_reg = 1'b1; end
      LD_FLT:  begin c.cntr4_filter_en = 1'b1; c.filter_wr_en = 1'b1; end
      LD_IMG:  begin
                 c.adr_sel = 1'b1; c.mem_offset_sel = 2'd1;
                 c.cntr16_img_en = 1'b1; c.img_wr_en = 1'b1;
               end
      SLICE:   begin c.img_slice_en = 1'b1; c.row_cntr_en = 1'b1; end
      MAC:     begin c.acc_en = 1'b1; c.cntr16_en = 1'b1; end
      PSUM:    begin c.res_buffer_en = 1'b1; c.cntr_reg4_en = 1'b1; c.col_cntr_en = 1'b1; end
      RST_ACC: c.rst_acc = 1'b1;
      WR:      begin
                 c.mem_en = 1'b1; c.mem_offset_sel = 2'd2; c.cntr43_en = 1'b1;
                 c.rst_res_reg = 1'b1; c.rst_acc = 1'b1;
               end
      NXT_ROW: begin c.inc_en = 1'b1; c.cntr13_en = 1'b1; c.rst_acc = 1'b1; end
      FIN:     c.wr_file = 1'b1;
      DONE:    c.done = 1'b1;
      default: c.busy = 1'b0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d    = state_q;
    col_wrap_d = col_wrap_q;
    done_cnt_d = done_cnt_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = INIT;
      INIT:    state_d = LD_FLT;
      LD_FLT:  if (bus.co_cntr4_filter) state_d = LD_IMG;
      LD_IMG:  if (bus.co_cntr16_img) state_d = SLICE;
      SLICE:   if (bus.co_row_cntr) state_d = MAC;
      MAC:     if (bus.co_cntr16) state_d = PSUM;
      PSUM:    begin
                 if (bus.co_col_cntr) col_wrap_d = 1'b1;
                 state_d = bus.co_cntr_reg4 ? WR : RST_ACC;
               end
      RST_ACC: state_d = SLICE;
      WR:      state_d = (bus.co_cntr43 || col_wrap_q) ? NXT_ROW : SLICE;
      NXT_ROW: begin
                 col_wrap_d = 1'b0;
                 state_d    = bus.co_cntr13 ? FIN : LD_IMG;
               end
      FIN:     begin
                 state_d    = DONE;
                 done_cnt_d = '0;
               end
      DONE:    begin
                 if (done_cnt_q == CW'(DONE_CYCLES - 1)) state_d = IDLE;
                 else done_cnt_d = done_cnt_q + 1'b1;
               end
      default: state_d = IDLE;
    endcase
    ctrl_d = decode(state_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      col_wrap_q <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      col_wrap_q <= col_wrap_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign bus.busy            = ctrl_q.busy;
  assign bus.done            = ctrl_q.done;
  assign bus.mem_en          = ctrl_q.mem_en;
  assign bus.wr_file         = ctrl_q.wr_file;
  assign bus.adr_sel         = ctrl_q.adr_sel;
  assign bus.filter_wr_en    = ctrl_q.filter_wr_en;
  assign bus.img_wr_en       = ctrl_q.img_wr_en;
  assign bus.cntr4_filter_en = ctrl_q.cntr4_filter_en;
  assign bus.cntr16_img_en   = ctrl_q.cntr16_img_en;
  assign bus.row_cntr_en     = ctrl_q.row_cntr_en;
  assign bus.col_cntr_en     = ctrl_q.col_cntr_en;
  assign bus.cntr16_en       = ctrl_q.cntr16_en;
  assign bus.img_slice_en    = ctrl_q.img_slice_en;
  assign bus.acc_en          = ctrl_q.acc_en;
  assign bus.cntr_reg4_en    = ctrl_q.cntr_reg4_en;
  assign bus.res_buffer_en   = ctrl_q.res_buffer_en;
  assign bus.cntr43_en       = ctrl_q.cntr43_en;
  assign bus.cntr13_en       = ctrl_q.cntr13_en;
  assign bus.inc_en          = ctrl_q.inc_en;
  assign bus.inc_ld          = ctrl_q.inc_ld;
  assign bus.rst_acc         = ctrl_q.rst_acc;
  assign bus.rst_res_reg     = ctrl_q.rst_res_reg;
  assign bus.mem_offset_sel  = ctrl_q.mem_offset_sel;

endmodule

// File: tb/tb_conv_controller.sv
// Directed bench for conv_controller: a small datapath carry-out model runs a
// two-row convolution (13 columns, 4 results per word) plus reset and abort cases.
module tb_conv_controller;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  conv_controller_if cif ();

  conv_controller #(.DONE_CYCLES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (cif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] all_outs;
  assign all_outs = {cif.mem_en, cif.wr_file, cif.adr_sel, cif.filter_wr_en, cif.img_wr_en,
                     cif.cntr4_filter_en, cif.cntr16_img_en, cif.row_cntr_en, cif.col_cntr_en,
                     cif.cntr16_en, cif.img_slice_en, cif.acc_en, cif.cntr_reg4_en,
                     cif.res_buffer_en, cif.cntr43_en, cif.cntr13_en, cif.inc_en, cif.inc_ld,
                     cif.rst_acc, cif.rst_res_reg, cif.mem_offset_sel, cif.busy, cif.done};

  // Datapath counter model: carry-out fires combinationally on the last enabled count.
  logic [1:0] f_cnt, r_cnt, g_cnt;
  logic [3:0] i_cnt, m_cnt, c_cnt;
  logic       n_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_cnt <= '0; r_cnt <= '0; g_cnt <= '0;
      i_cnt <= '0; m_cnt <= '0; c_cnt <= '0; n_cnt <= 1'b0;
    end else begin
      if (cif.cntr4_filter_en) f_cnt <= f_cnt + 2'd1;
      if (cif.cntr16_img_en)   i_cnt <= i_cnt + 4'd1;
      if (cif.row_cntr_en)     r_cnt <= r_cnt + 2'd1;
      if (cif.cntr16_en)       m_cnt <= m_cnt + 4'd1;
      if (cif.cntr13_en)       n_cnt <= ~n_cnt;
      if (cif.inc_en) begin
        g_cnt <= '0;
        c_cnt <= '0;
      end else begin
        if (cif.cntr_reg4_en) g_cnt <= g_cnt + 2'd1;
        if (cif.col_cntr_en)  c_cnt <= (c_cnt == 4'd12) ? 4'd0 : c_cnt + 4'd1;
      end
    end
  end

  assign cif.co_cntr4_filter = cif.cntr4_filter_en && (f_cnt == 2'd3);
  assign cif.co_cntr16_img   = cif.cntr16_img_en   && (i_cnt == 4'd15);
  assign cif.co_row_cntr     = cif.row_cntr_en     && (r_cnt == 2'd3);
  assign cif.co_cntr16       = cif.cntr16_en       && (m_cnt == 4'd15);
  assign cif.co_cntr_reg4    = cif.cntr_reg4_en    && (g_cnt == 2'd3);
  assign cif.co_col_cntr     = cif.col_cntr_en     && (c_cnt == 4'd12);
  assign cif.co_cntr13       = cif.cntr13_en       && n_cnt;
  assign cif.co_cntr43       = 1'b0;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)",
               tag, observed, observed, expected, expected);
    end
  endtask

  // Pulse start for one cycle; returns at the sample point of the cycle after sampling.
  task automatic apply_start_pulse();
    cif.start = 1'b1;
    @(negedge clk);
    cif.start = 1'b0;
  endtask

  int  flt_cyc, flt_badsel, img_cyc, img_badsel, acc_cyc, acc_bursts, acc_badburst, acc_run;
  int  res_cyc, first_acc, first_res, mem_cyc, mem_badsel, mem_collide, inc_cyc;
  int  wr_then_nxt, nxt_then_ldimg, nxt_then_fin, wr_file_cyc, done_cyc, busy_cyc;
  int  busy_done_bad, idle_busy, n;
  logic prev_mem, prev_inc, prev_done, prev_acc, finished;

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    cif.start = 1'b1;

    // Reset held with start high
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_outputs_zero", 32'(all_outs), 32'd0);
    cif.start = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    check_output("reset_release_idle", 32'(all_outs), 32'd0);

    // Full run: INIT cycle first
    apply_start_pulse();
    check_output("init_vector",
                 32'({cif.inc_ld, cif.rst_acc, cif.rst_res_reg, cif.busy, cif.filter_wr_en, cif.mem_en}),
                 32'b111100);

    flt_cyc = 0; flt_badsel = 0; img_cyc = 0; img_badsel = 0; acc_cyc = 0;
    acc_bursts = 0; acc_badburst = 0; acc_run = 0; res_cyc = 0; first_acc = 0; first_res = 0;
    mem_cyc = 0; mem_badsel = 0; mem_collide = 0; inc_cyc = 0; wr_then_nxt = 0;
    nxt_then_ldimg = 0; nxt_then_fin = 0; wr_file_cyc = 0; done_cyc = 0; busy_cyc = 0;
    busy_done_bad = 0;
    prev_mem = 0; prev_inc = 0; prev_done = 0; prev_acc = 0; finished = 0;

    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      if (prev_done && !cif.done) begin
        finished = 1'b1;
        if (cif.busy) busy_done_bad++;
      end else begin
        if (cif.busy) busy_cyc++;
        if (cif.filter_wr_en) begin
          flt_cyc++;
          if (cif.mem_offset_sel != 2'd0 || cif.adr_sel) flt_badsel++;
        end
        if (cif.img_wr_en) begin
          img_cyc++;
          if (cif.mem_offset_sel != 2'd1 || !cif.adr_sel) img_badsel++;
        end
        if (cif.acc_en) begin
          acc_cyc++;
          acc_run++;
        end else if (prev_acc) begin
          acc_bursts++;
          if (acc_run != 16) acc_badburst++;
          acc_run = 0;
        end
        if (mem_cyc == 0 && cif.acc_en) first_acc++;
        if (mem_cyc == 0 && cif.res_buffer_en) first_res++;
        if (cif.res_buffer_en) res_cyc++;
        if (cif.mem_en) begin
          mem_cyc++;
          if (cif.mem_offset_sel != 2'd2 || !cif.rst_res_reg) mem_badsel++;
          if (cif.filter_wr_en || cif.img_wr_en) mem_collide++;
        end
        if (cif.inc_en) inc_cyc++;
        if (prev_mem && cif.inc_en && cif.cntr13_en) wr_then_nxt++;
        if (prev_inc && cif.img_wr_en) nxt_then_ldimg++;
        if (prev_inc && cif.wr_file) nxt_then_fin++;
        if (cif.wr_file) wr_file_cyc++;
        if (cif.done) begin
          done_cyc++;
          if (!cif.busy) busy_done_bad++;
        end
        cif.start = (cif.done && !prev_done);
        prev_mem  = cif.mem_en;
        prev_inc  = cif.inc_en;
        prev_done = cif.done;
        prev_acc  = cif.acc_en;
        @(negedge clk);
      end
    end
    cif.start = 1'b0;

    check_output("run_completed", 32'(finished), 32'd1);
    check_output("filter_wr_cycles", flt_cyc, 4);
    check_output("filter_sel_bad", flt_badsel, 0);
    check_output("img_wr_cycles", img_cyc, 32);
    check_output("img_sel_bad", img_badsel, 0);
    check_output("acc_cycles", acc_cyc, 512);
    check_output("acc_bursts", acc_bursts, 32);
    check_output("acc_burst_len_bad", acc_badburst, 0);
    check_output("acc_before_first_wr", first_acc, 64);
    check_output("res_before_first_wr", first_res, 4);
    check_output("res_buffer_pulses", res_cyc, 32);
    check_output("mem_en_pulses", mem_cyc, 8);
    check_output("mem_sel_bad", mem_badsel, 0);
    check_output("mem_collide", mem_collide, 0);
    check_output("wr_then_nxt_row", wr_then_nxt, 2);
    check_output("inc_en_cycles", inc_cyc, 2);
    check_output("nxt_row_to_ld_img", nxt_then_ldimg, 1);
    check_output("nxt_row_to_fin", nxt_then_fin, 1);
    check_output("wr_file_cycles", wr_file_cyc, 1);
    check_output("done_cycles", done_cyc, 3);
    check_output("busy_cycles", busy_cyc, 747);
    check_output("busy_vs_done_bad", busy_done_bad, 0);

    // The start pulse seen during DONE must not launch a run
    idle_busy = 0;
    repeat (4) begin
      @(negedge clk);
      if (cif.busy) idle_busy++;
    end
    check_output("start_in_done_ignored", idle_busy, 0);

    // Abort in the 7th MAC cycle
    apply_start_pulse();
    n = 0;
    for (int cyc = 0; cyc < 200 && n < 7; cyc++) begin
      @(negedge clk);
      if (cif.acc_en) n++;
    end
    check_output("abort_reached_mac7", n, 7);
    rst = 1'b0;
    #1;
    check_output("abort_async_clear", 32'(all_outs), 32'd0);
    @(negedge clk);
    check_output("abort_hold_clear", 32'(all_outs), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_output("abort_release_idle", 32'(cif.busy), 32'd0);
    apply_start_pulse();
    check_output("rerun_init_vector",
                 32'({cif.inc_ld, cif.rst_acc, cif.rst_res_reg, cif.busy, cif.acc_en, cif.mem_en}),
                 32'b111100);
    @(negedge clk);
    check_output("rerun_ld_flt",
                 32'({cif.filter_wr_en, cif.cntr4_filter_en, cif.mem_offset_sel, cif.busy}),
                 32'b11001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
